// File: rtl/player_mover_if.sv
// Bundles the player controls, the map-query handshake and the position/bomb
// outputs of one player_mover instance.
interface player_mover_if;
    logic       enable;
    logic       xmov;
    logic       xdir;
    logic       ymov;
    logic       ydir;
    logic       bomb;
    logic       query_req;
    logic [3:0] query_x;
    logic [3:0] query_y;
    logic       query_ack;
    logic       query_blocked;
    logic [3:0] pos_x;
    logic [3:0] pos_y;
    logic       moved;
    logic       bomb_req;
    logic [3:0] bomb_x;
    logic [3:0] bomb_y;

    modport master (
        output enable, xmov, xdir, ymov, ydir, bomb, query_ack, query_blocked,
        input  query_req, query_x, query_y, pos_x, pos_y, moved,
               bomb_req, bomb_x, bomb_y
    );

    modport slave (
        input  enable, xmov, xdir, ymov, ydir, bomb, query_ack, query_blocked,
        output query_req, query_x, query_y, pos_x, pos_y, moved,
               bomb_req, bomb_x, bomb_y
    );
endinterface

// File: rtl/player_mover.sv
// Grid player controller: steps one cell per accepted move after a map query,
// enforces a cooldown between moves and emits edge-triggered bomb requests.
module player_mover #(
    parameter int GRID_W     = 15,
    parameter int GRID_H     = 11,
    parameter int START_X    = 1,
    parameter int START_Y    = 1,
    parameter int MOVE_DELAY = 5000000
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    player_mover_if.slave pm
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_QUERY = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] x;
        logic [3:0] y;
    } cell_t;

    localparam logic [3:0]  X_MAX     = 4'(GRID_W - 1);
    localparam logic [3:0]  Y_MAX     = 4'(GRID_H - 1);
    localparam logic [3:0]  X_RESET   = 4'(START_X);
    localparam logic [3:0]  Y_RESET   = 4'(START_Y);
    localparam logic [31:0] WAIT_LAST = 32'(MOVE_DELAY - 2);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  tgt_x_q, tgt_x_d;
    logic [3:0]  tgt_y_q, tgt_y_d;
    logic [3:0]  pos_x_q, pos_x_d;
    logic [3:0]  pos_y_q, pos_y_d;
    logic        query_req_q, query_req_d;
    logic        moved_q, moved_d;
    logic        bomb_prev_q;
    logic        bomb_req_q, bomb_req_d;
    logic [3:0]  bomb_x_q, bomb_x_d;
    logic [3:0]  bomb_y_q, bomb_y_d;
    logic        bomb_edge_s;
    cell_t       step_s;

    // X movement wins over Y; a step that would leave the grid is reported invalid.
    function automatic cell_t next_cell(
        input logic       xmov,
        input logic       xdir,
        input logic       ymov,
        input logic       ydir,
        input logic [3:0] px,
        input logic [3:0] py
    );
        cell_t c;
        c.valid = 1'b0;
        c.x     = px;
        c.y     = py;
        if (xmov) begin
            if (xdir) begin
                c.valid = (px != X_MAX);
                c.x     = px + 4'd1;
            end else begin
                c.valid = (px != 4'd0);
                c.x     = px - 4'd1;
            end
        end else if (ymov) begin
            if (ydir) begin
                c.valid = (py != Y_MAX);
                c.y     = py + 4'd1;
            end else begin
                c.valid = (py != 4'd0);
                c.y     = py - 4'd1;
            end
        end else begin
            c.valid = 1'b0;
        end
        return c;
    endfunction

    // Movement FSM: next state, target latch, position update and cooldown counter.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tgt_x_d     = tgt_x_q;
        tgt_y_d     = tgt_y_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        query_req_d = 1'b0;
        moved_d     = 1'b0;
        step_s      = next_cell(pm.xmov, pm.xdir, pm.ymov, pm.ydir, pos_x_q, pos_y_q);
        case (state_q)
            ST_IDLE: begin
                if (pm.enable && step_s.valid) begin
                    tgt_x_d     = step_s.x;
                    tgt_y_d     = step_s.y;
                    query_req_d = 1'b1;
                    state_d     = ST_QUERY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_QUERY: begin
                if (pm.query_ack) begin
                    if (pm.query_blocked) begin
                        state_d = ST_IDLE;
                    end else begin
                        pos_x_d = tgt_x_q;
                        pos_y_d = tgt_y_q;
                        moved_d = 1'b1;
                        cnt_d   = 32'd0;
                        state_d = ST_WAIT;
                    end
                end else begin
                    query_req_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bomb key edge detect; coordinates taken from the position held before any same-cycle move.
    always_comb begin
        bomb_edge_s = pm.bomb & ~bomb_prev_q;
        bomb_req_d  = bomb_edge_s & pm.enable;
        if (bomb_req_d) begin
            bomb_x_d = pos_x_q;
            bomb_y_d = pos_y_q;
        end else begin
            bomb_x_d = bomb_x_q;
            bomb_y_d = bomb_y_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 32'd0;
            tgt_x_q     <= 4'd0;
            tgt_y_q     <= 4'd0;
            pos_x_q     <= X_RESET;
            pos_y_q     <= Y_RESET;
            query_req_q <= 1'b0;
            moved_q     <= 1'b0;
            bomb_prev_q <= 1'b0;
            bomb_req_q  <= 1'b0;
            bomb_x_q    <= 4'd0;
            bomb_y_q    <= 4'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tgt_x_q     <= tgt_x_d;
            tgt_y_q     <= tgt_y_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            query_req_q <= query_req_d;
            moved_q     <= moved_d;
            bomb_prev_q <= pm.bomb;
            bomb_req_q  <= bomb_req_d;
            bomb_x_q    <= bomb_x_d;
            bomb_y_q    <= bomb_y_d;
        end
    end

    assign pm.query_req = query_req_q;
    assign pm.query_x   = tgt_x_q;
    assign pm.query_y   = tgt_y_q;
    assign pm.pos_x     = pos_x_q;
    assign pm.pos_y     = pos_y_q;
    assign pm.moved     = moved_q;
    assign pm.bomb_req  = bomb_req_q;
    assign pm.bomb_x    = bomb_x_q;
    assign pm.bomb_y    = bomb_y_q;

endmodule
